ic_fill_ctrl: RTL

IC_FILL_CTRL -- requirements
Module: ic_fill_ctrl

---
 rtl/ic_fill_ctrl_if.sv | 43 ++++
 rtl/ic_fill_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ic_fill_ctrl_if.sv
// ---------------------------------------------------------------------------
// ic_fill_ctrl_if
// Groups the icache-side miss/fill handshake and the memory-side read
// request/beat bus used by ic_fill_ctrl.
//
// Signals:
//   ic_miss          icache miss request (level)
//   ic_miss_addr     miss line address (low 5 bits expected zero)
//   ic_fill_data     assembled 256-bit line presented to the icache
//   ic_miss_ack      one-cycle fill-complete pulse
//   ic_miss_ack_addr line address being written back
//   mem_req          memory read request (level)
//   mem_addr         line address presented with mem_req
//   mem_gnt          memory accepts the request
//   mem_rvalid       one 32-bit beat valid this cycle
//   mem_rdata        beat data
//
// Modports:
//   master  fill-controller side (drives mem_req and the icache fill outputs)
//   slave   environment side (icache + memory)
// ---------------------------------------------------------------------------
interface ic_fill_ctrl_if;
  logic         ic_miss;
  logic [31:0]  ic_miss_addr;
  logic [255:0] ic_fill_data;
  logic         ic_miss_ack;
  logic [31:0]  ic_miss_ack_addr;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;

  modport master (
    input  ic_miss, ic_miss_addr, mem_gnt, mem_rvalid, mem_rdata,
    output ic_fill_data, ic_miss_ack, ic_miss_ack_addr, mem_req, mem_addr
  );

  modport slave (
    output ic_miss, ic_miss_addr, mem_gnt, mem_rvalid, mem_rdata,
    input  ic_fill_data, ic_miss_ack, ic_miss_ack_addr, mem_req, mem_addr
  );
endinterface

// File: rtl/ic_fill_ctrl.sv
// ---------------------------------------------------------------------------
// ic_fill_ctrl
// Instruction-cache line fill controller. On a miss it latches the line
// address, issues one memory read request, collects eight 32-bit beats into
// a 256-bit line and pulses ic_miss_ack for one cycle so the icache can
// write the line.
//
// Ports:
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   bus            ic_fill_ctrl_if.master (icache + memory handshakes)
//   busy           high whenever the controller is not idle
//   perf_miss_cnt  number of completed fills, saturating at 16'hFFFF
//
// Configuration:
//   IC_FILL_PERF_EN  when defined, perf_miss_cnt counts completed fills;
//                    when undefined it is tied to zero.
// ---------------------------------------------------------------------------
module ic_fill_ctrl (
  input  logic                  clk,
  input  logic                  rst_n,
  ic_fill_ctrl_if.master        bus,
  output logic                  busy,
  output logic [15:0]           perf_miss_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BEAT = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [2:0]    beat_cnt;
  logic [31:0]   line_addr;
  logic [255:0]  fill_data;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a fill only ends after the eighth accepted beat,
  // and there is no timeout while waiting for grant or beats.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.ic_miss)                          state_next = REQ;
      REQ:  if (bus.mem_gnt)                          state_next = BEAT;
      BEAT: if (bus.mem_rvalid && (beat_cnt == 3'd7)) state_next = ACK;
      ACK:                                            state_next = IDLE;
      default:                                        state_next = IDLE;
    endcase
  end

  // Output logic; everything here depends on state only
  always_comb begin
    bus.mem_req     = 1'b0;
    bus.ic_miss_ack = 1'b0;
    busy            = 1'b1;
    case (state)
      IDLE:    busy            = 1'b0;
      REQ:     bus.mem_req     = 1'b1;
      ACK:     bus.ic_miss_ack = 1'b1;
      default: ;
    endcase
  end

  // Line address capture. The low five bits are masked so a misaligned
  // miss address still selects the enclosing 32-byte line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_addr <= '0;
    end else if ((state == IDLE) && bus.ic_miss) begin
      line_addr <= bus.ic_miss_addr & 32'hFFFF_FFE0;
    end
  end

  // Beat counter and line assembly. The counter is 3 bits so it wraps
  // 7->0 naturally on the last beat; it is also cleared when a miss is
  // accepted so a fill always starts at slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      fill_data <= '0;
    end else if ((state == IDLE) && bus.ic_miss) begin
      beat_cnt  <= '0;
    end else if ((state == BEAT) && bus.mem_rvalid) begin
      fill_data[{beat_cnt, 5'b00000} +: 32] <= bus.mem_rdata;
      beat_cnt                              <= beat_cnt + 3'd1;
    end
  end

  assign bus.mem_addr         = line_addr;
  assign bus.ic_miss_ack_addr = line_addr;
  assign bus.ic_fill_data     = fill_data;

`ifdef IC_FILL_PERF_EN
  logic [15:0] miss_cnt;

  // Completed-fill counter, saturating so it never rolls back to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt <= '0;
    end else if ((state == ACK) && (miss_cnt != 16'hFFFF)) begin
      miss_cnt <= miss_cnt + 16'd1;
    end
  end

  assign perf_miss_cnt = miss_cnt;
`else
  assign perf_miss_cnt = 16'd0;
`endif

endmodule
